// File: rtl/stall_ctrl_pkg.sv
// Shared CPU control package: stall FSM state encodings,
// pipeline opcode constants and the control-bundle type.
package stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_HALTED   = 2'b10
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_HALT   = 7'b1110011;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic idex_we;
      logic exmem_we;
      logic memwb_we;
      logic ifid_flush;
      logic idex_bubble;
   } ctrl_t;

   function automatic ctrl_t ctrl_make(
      input logic pc,
      input logic ifid,
      input logic flush,
      input logic bubble,
      input logic rest
   );
      ctrl_t c;
      c.pc_we       = pc;
      c.ifid_we     = ifid;
      c.idex_we     = rest;
      c.exmem_we    = rest;
      c.memwb_we    = rest;
      c.ifid_flush  = flush;
      c.idex_bubble = bubble;
      return c;
   endfunction

endpackage

// File: rtl/stall_ctrl_sat_cnt16.sv
// 16-bit event counter with enable, synchronous clear and
// saturation at all-ones.
module sat_cnt16 (
   input  logic        clk,
   input  logic        i_clr,
   input  logic        i_en,
   output logic [15:0] o_q
);

   logic [15:0] r_q;

   always_ff @(posedge clk) begin
      if (i_clr)
         r_q <= 16'd0;
      else if (i_en && (r_q != 16'hFFFF))
         r_q <= r_q + 16'd1;
   end

   assign o_q = r_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush/halt controller for the 5-stage core.
// Optional stall/flush counters: define STALL_CTRL_CNT_EN.
module stall_ctrl
   import stall_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_stall,
   input  logic        branch_taken,
   input  logic        imem_stall,
   input  logic        dmem_stall,
   input  logic        memwb_halt,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_we,
   output logic        exmem_we,
   output logic        memwb_we,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        halted,
   output logic        err
`ifdef STALL_CTRL_CNT_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   state_e r_state;
   state_e w_next;
   ctrl_t  w_ctrl;
   logic   w_halted;
   logic   w_live;
   logic   r_haz_prev;
   logic   r_err;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_RUN;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RUN, ST_MEM_WAIT: begin
            if (memwb_halt)
               w_next = ST_HALTED;
            else if (dmem_stall)
               w_next = ST_MEM_WAIT;
            else
               w_next = ST_RUN;
         end
         ST_HALTED: w_next = ST_HALTED;
         default:   w_next = ST_RUN;
      endcase
   end

   // MEM_WAIT shares the RUN decode: releasing dmem_stall
   // resumes normal steering in that same cycle.
   always_comb begin
      w_ctrl   = ctrl_make(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      w_halted = 1'b0;
      if (rst) begin
         w_ctrl = ctrl_make(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end else begin
         case (r_state)
            ST_HALTED: w_halted = 1'b1;
            default: begin
               if (memwb_halt || dmem_stall)
                  w_ctrl = ctrl_make(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               else if (branch_taken)
                  w_ctrl = ctrl_make(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
               else if (hazard_stall)
                  w_ctrl = ctrl_make(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
               else if (imem_stall)
                  w_ctrl = ctrl_make(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
               else
                  w_ctrl = ctrl_make(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            end
         endcase
      end
   end

   // Frozen and halting cycles leave the hazard history untouched.
   assign w_live = (r_state != ST_HALTED) && !memwb_halt && !dmem_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_haz_prev <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_live) begin
         r_haz_prev <= hazard_stall;
         if (hazard_stall && r_haz_prev)
            r_err <= 1'b1;
      end
   end

   assign pc_we       = w_ctrl.pc_we;
   assign ifid_we     = w_ctrl.ifid_we;
   assign idex_we     = w_ctrl.idex_we;
   assign exmem_we    = w_ctrl.exmem_we;
   assign memwb_we    = w_ctrl.memwb_we;
   assign ifid_flush  = w_ctrl.ifid_flush;
   assign idex_bubble = w_ctrl.idex_bubble;
   assign halted      = w_halted;
   assign err         = r_err && !rst;

`ifdef STALL_CTRL_CNT_EN
   logic w_stall_en;
   logic w_flush_en;

   assign w_stall_en = !w_ctrl.pc_we && (r_state != ST_HALTED);
   assign w_flush_en = w_ctrl.ifid_flush && !rst;

   sat_cnt16 u_stall_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (w_stall_en),
      .o_q   (stall_cycles)
   );

   sat_cnt16 u_flush_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (w_flush_en),
      .o_q   (flush_count)
   );
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl; counter tests
// run only when STALL_CTRL_CNT_EN is defined.
module tb_stall_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic hazard_stall, branch_taken, imem_stall, dmem_stall, memwb_halt;
   logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic ifid_flush, idex_bubble, halted, err;
`ifdef STALL_CTRL_CNT_EN
   logic [15:0] stall_cycles, flush_count;
`endif

   int cnt_run  = 0;
   int cnt_fail = 0;

   // {pc,ifid,idex,exmem,memwb, flush,bubble, halted,err}
   logic [8:0] obs;
   assign obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                 ifid_flush, idex_bubble, halted, err};

   localparam logic [8:0] V_NORM  = 9'b11111_00_00;
   localparam logic [8:0] V_NORME = 9'b11111_00_01;
   localparam logic [8:0] V_HAZ   = 9'b00111_01_00;
   localparam logic [8:0] V_BR    = 9'b11111_11_00;
   localparam logic [8:0] V_IMEM  = 9'b01111_10_00;
   localparam logic [8:0] V_FRZ   = 9'b00000_00_00;
   localparam logic [8:0] V_HLT   = 9'b00000_00_10;
   localparam logic [8:0] V_RST   = 9'b00000_11_00;

   always #5 clk = ~clk;

   stall_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .hazard_stall (hazard_stall),
      .branch_taken (branch_taken),
      .imem_stall   (imem_stall),
      .dmem_stall   (dmem_stall),
      .memwb_halt   (memwb_halt),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .idex_we      (idex_we),
      .exmem_we     (exmem_we),
      .memwb_we     (memwb_we),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .halted       (halted),
      .err          (err)
`ifdef STALL_CTRL_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic h, input logic b,
                        input logic i, input logic d, input logic m);
      rst          = r;
      hazard_stall = h;
      branch_taken = b;
      imem_stall   = i;
      dmem_stall   = d;
      memwb_halt   = m;
      #2;
   endtask

   task automatic test_reset();
      drive(1, 1, 1, 1, 0, 0);
      cnt_run++;
      if (obs !== V_RST) begin
         cnt_fail++;
         $display("FAIL reset_out got %b want %b", obs, V_RST);
      end
      tick();
`ifdef STALL_CTRL_CNT_EN
      cnt_run++;
      if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
         cnt_fail++;
         $display("FAIL reset_cnt got %h/%h want 0000/0000",
                  stall_cycles, flush_count);
      end
`endif
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL run_idle got %b want %b", obs, V_NORM);
      end
      tick();
   endtask

   task automatic test_hazard();
      drive(0, 1, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_HAZ) begin
         cnt_fail++;
         $display("FAIL hazard_one got %b want %b", obs, V_HAZ);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL hazard_after got %b want %b", obs, V_NORM);
      end
      tick();
   endtask

   task automatic test_dmem_freeze();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 0, 1, 0);
         cnt_run++;
         if (obs !== V_FRZ) begin
            cnt_fail++;
            $display("FAIL dmem_frz%0d got %b want %b", k, obs, V_FRZ);
         end
         tick();
      end
      drive(0, 1, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_HAZ) begin
         cnt_fail++;
         $display("FAIL dmem_release got %b want %b", obs, V_HAZ);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL dmem_normal got %b want %b", obs, V_NORM);
      end
      tick();
   endtask

   task automatic test_priority();
      drive(0, 1, 1, 1, 0, 0);
      cnt_run++;
      if (obs !== V_BR) begin
         cnt_fail++;
         $display("FAIL branch_over got %b want %b", obs, V_BR);
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      cnt_run++;
      if (obs !== V_IMEM) begin
         cnt_fail++;
         $display("FAIL imem_only got %b want %b", obs, V_IMEM);
      end
      tick();
      drive(0, 1, 0, 1, 0, 0);
      cnt_run++;
      if (obs !== V_HAZ) begin
         cnt_fail++;
         $display("FAIL haz_over_imem got %b want %b", obs, V_HAZ);
      end
      tick();
      drive(0, 0, 1, 0, 1, 0);
      cnt_run++;
      if (obs !== V_FRZ) begin
         cnt_fail++;
         $display("FAIL dmem_over_br got %b want %b", obs, V_FRZ);
      end
      tick();
      drive(0, 0, 1, 0, 0, 0);
      cnt_run++;
      if (obs !== V_BR) begin
         cnt_fail++;
         $display("FAIL br_after_wait got %b want %b", obs, V_BR);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_err();
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL err_broken got %b want %b", obs, V_NORM);
      end
      tick();
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_HAZ) begin
         cnt_fail++;
         $display("FAIL err_second got %b want %b", obs, V_HAZ);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0);
         cnt_run++;
         if (obs !== V_NORME) begin
            cnt_fail++;
            $display("FAIL err_hold%0d got %b want %b", k, obs, V_NORME);
         end
         tick();
      end
      drive(1, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_RST) begin
         cnt_fail++;
         $display("FAIL err_in_rst got %b want %b", obs, V_RST);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL err_cleared got %b want %b", obs, V_NORM);
      end
      tick();
      // a frozen cycle between two hazards does not break the pair
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORME) begin
         cnt_fail++;
         $display("FAIL err_frozen_gap got %b want %b", obs, V_NORME);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_halt();
      drive(0, 0, 0, 0, 0, 1);
      cnt_run++;
      if (obs !== V_FRZ) begin
         cnt_fail++;
         $display("FAIL halt_cycle got %b want %b", obs, V_FRZ);
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(0, k[0], k[1], k[2], k[3], ~k[0]);
         cnt_run++;
         if (obs !== V_HLT) begin
            cnt_fail++;
            $display("FAIL halted%0d got %b want %b", k, obs, V_HLT);
         end
         tick();
      end
      drive(1, 1, 0, 0, 0, 1);
      cnt_run++;
      if (obs !== V_RST) begin
         cnt_fail++;
         $display("FAIL halt_rst got %b want %b", obs, V_RST);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (obs !== V_NORM) begin
         cnt_fail++;
         $display("FAIL halt_exit got %b want %b", obs, V_NORM);
      end
      tick();
      // halt arriving while waiting on data memory
      drive(0, 0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 1, 1);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      cnt_run++;
      if (obs !== V_HLT) begin
         cnt_fail++;
         $display("FAIL halt_from_wait got %b want %b", obs, V_HLT);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_rst_memwait();
      drive(0, 0, 0, 0, 1, 0);
      tick();
      drive(1, 0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      cnt_run++;
      if (obs !== V_BR) begin
         cnt_fail++;
         $display("FAIL rst_wait_exit got %b want %b", obs, V_BR);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

`ifdef STALL_CTRL_CNT_EN
   task automatic test_counters();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 1, 0, 0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 1, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      cnt_run++;
      if (stall_cycles !== 16'd5) begin
         cnt_fail++;
         $display("FAIL cnt_stall got %0d want 5", stall_cycles);
      end
      cnt_run++;
      if (flush_count !== 16'd7) begin
         cnt_fail++;
         $display("FAIL cnt_flush got %0d want 7", flush_count);
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      repeat (65540) @(posedge clk);
      #1;
      cnt_run++;
      if (stall_cycles !== 16'hFFFF || flush_count !== 16'hFFFF) begin
         cnt_fail++;
         $display("FAIL cnt_sat got %h/%h want ffff/ffff",
                  stall_cycles, flush_count);
      end
      tick();
      cnt_run++;
      if (stall_cycles !== 16'hFFFF || flush_count !== 16'hFFFF) begin
         cnt_fail++;
         $display("FAIL cnt_sat_hold got %h/%h want ffff/ffff",
                  stall_cycles, flush_count);
      end
      drive(1, 0, 0, 0, 0, 0);
      tick();
      cnt_run++;
      if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
         cnt_fail++;
         $display("FAIL cnt_clear got %h/%h want 0000/0000",
                  stall_cycles, flush_count);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask
`endif

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      tick();
      tick();
      test_reset();
      test_hazard();
      test_dmem_freeze();
      test_priority();
      test_err();
      test_halt();
      test_rst_memwait();
`ifdef STALL_CTRL_CNT_EN
      test_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
      $finish;
   end

endmodule
